// File: rtl/cali_pkg.sv
// Shared constants and state encoding for the calibration RAM port-2 sequencer.
package cali_pkg;
  localparam int NUM_CH = 320;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] INIT_VAL = 16'h4000;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_STREAM = 2'd2,
    ST_VERIFY = 2'd3
  } state_e;
endpackage

// File: rtl/cali_ch_counter.sv
// Wrapping 0..NUM_CH-1 counter shared by the fill address and the stream channel.
// 'cur' is the value in use this cycle (zero when clr is high), so clr+en yields 1 next.
module cali_ch_counter
  import cali_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] cnt,
  output logic [ADDR_W-1:0] cur,
  output logic              last
);
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cur   = clr ? '0 : cnt_q;
    last  = (cur == ADDR_W'(NUM_CH - 1));
    cnt_d = cur;
    if (en) cnt_d = last ? '0 : cur + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/cali_ram_seq.sv
// Port-2 sequencer: fills the calibration RAM, then pairs each sample with its coefficient.
// Optional readback verify after each fill is enabled by CALI_READBACK_CHECK_EN.
module cali_ram_seq
  import cali_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              init_req,
  output logic              init_busy,
  input  logic              frame_start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic [DATA_W-1:0] m_coef,
  output logic [ADDR_W-1:0] m_ch,
  output logic              m_last,
  output logic              frame_err,
  output logic [15:0]       drop_cnt,
`ifdef CALI_READBACK_CHECK_EN
  output logic              init_fail,
`endif
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [1:0]        ram_byteenable,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);
`ifdef CALI_READBACK_CHECK_EN
  localparam state_e FILL_DONE = ST_VERIFY;
`else
  localparam state_e FILL_DONE = ST_IDLE;
`endif

  state_e state_q, state_d;
  logic pending_q, pending_d;
  logic m_valid_q, m_valid_d, m_last_q, m_last_d, frame_err_q, frame_err_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [ADDR_W-1:0] m_ch_q, m_ch_d;
  logic [15:0] drop_q, drop_d;
  logic ctr_clr, ctr_en, fire, drop, err;
  logic [ADDR_W-1:0] ch_cnt, ch;
  logic ch_last;
`ifdef CALI_READBACK_CHECK_EN
  logic tail_q, tail_d, chk_q, chk_d, fail_q, fail_d;
`endif

  cali_ch_counter u_ctr (
    .clk   (clk),
    .reset (reset),
    .clr   (ctr_clr),
    .en    (ctr_en),
    .cnt   (ch_cnt),
    .cur   (ch),
    .last  (ch_last)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    ctr_clr   = 1'b0;
    ctr_en    = 1'b0;
    fire      = 1'b0;
    drop      = 1'b0;
    err       = 1'b0;
`ifdef CALI_READBACK_CHECK_EN
    tail_d    = tail_q;
`endif
    unique case (state_q)
      ST_INIT: begin
        ctr_en    = 1'b1;
        drop      = s_valid;
        err       = frame_start;
        pending_d = 1'b0;
        if (ch_last) state_d = FILL_DONE;
      end
      ST_IDLE: begin
        if (init_req) begin
          state_d = ST_INIT;
          ctr_clr = 1'b1;
          err     = frame_start;
          drop    = s_valid;
        end else if (frame_start) begin
          state_d = ST_STREAM;
          ctr_clr = 1'b1;
          fire    = s_valid;
          ctr_en  = s_valid;
        end else begin
          drop = s_valid;
        end
      end
      ST_STREAM: begin
        ctr_clr = frame_start;
        err     = frame_start && (ch_cnt != '0);
        fire    = s_valid;
        ctr_en  = s_valid;
        if (s_valid && ch_last) begin
          state_d   = (pending_q || init_req) ? ST_INIT : ST_IDLE;
          pending_d = 1'b0;
        end else if (init_req) begin
          pending_d = 1'b1;
        end
      end
      default: begin
`ifdef CALI_READBACK_CHECK_EN
        drop = s_valid;
        err  = frame_start;
        if (tail_q) begin
          state_d = ST_IDLE;
          tail_d  = 1'b0;
        end else begin
          ctr_en = 1'b1;
          if (ch_last) tail_d = 1'b1;
        end
`else
        state_d = ST_INIT;
`endif
      end
    endcase
  end

  always_comb begin
    ram_address    = ch;
    ram_byteenable = 2'b11;
    ram_writedata  = INIT_VAL;
    ram_clken      = 1'b1;
    ram_write      = (state_q == ST_INIT);
    ram_chipselect = 1'b0;
    unique case (state_q)
      ST_INIT:   ram_chipselect = 1'b1;
      ST_STREAM: ram_chipselect = fire;
      ST_IDLE:   ram_chipselect = fire;
`ifdef CALI_READBACK_CHECK_EN
      default:   ram_chipselect = !tail_q;
`else
      default:   ram_chipselect = 1'b0;
`endif
    endcase
    init_busy = (state_q == ST_INIT) || (state_q == ST_VERIFY);
  end

  always_comb begin
    m_valid_d   = fire;
    m_last_d    = fire && ch_last;
    m_data_d    = fire ? s_data : m_data_q;
    m_ch_d      = fire ? ch : m_ch_q;
    frame_err_d = err;
    drop_d      = (drop && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
`ifdef CALI_READBACK_CHECK_EN
    chk_d  = (state_q == ST_VERIFY) && !tail_q;
    fail_d = fail_q || (chk_q && (ram_readdata != INIT_VAL));
    // A new fill starts with a clean verdict.
    if (state_d == ST_INIT && state_q != ST_INIT) fail_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_data_q    <= '0;
      m_ch_q      <= '0;
      frame_err_q <= 1'b0;
      drop_q      <= '0;
`ifdef CALI_READBACK_CHECK_EN
      tail_q      <= 1'b0;
      chk_q       <= 1'b0;
      fail_q      <= 1'b0;
`endif
    end else begin
      pending_q   <= pending_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      m_data_q    <= m_data_d;
      m_ch_q      <= m_ch_d;
      frame_err_q <= frame_err_d;
      drop_q      <= drop_d;
`ifdef CALI_READBACK_CHECK_EN
      tail_q      <= tail_d;
      chk_q       <= chk_d;
      fail_q      <= fail_d;
`endif
    end
  end

  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign m_data    = m_data_q;
  assign m_ch      = m_ch_q;
  assign m_coef    = m_valid_q ? ram_readdata : '0;
  assign frame_err = frame_err_q;
  assign drop_cnt  = drop_q;
`ifdef CALI_READBACK_CHECK_EN
  assign init_fail = fail_q;
`endif
endmodule
